uart_imem_loader: RTL and testbench

- UART boot loader: receives a program image over a serial line and writes it word-by-word into instruction memory through its write port (write_enable / data_input / address).
- Holds the processor core in reset while loading. Releases it when the image is complete.
- Sits beside instruction_memory at the top level. Drives the memory's write side, while the core only ever reads it.

---
 rtl/uart_imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a length-prefixed image and writes it into instruction memory while
// holding the core in reset. Define UART_IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module uart_imem_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {SLen0, SLen1, SData, SCsum, SDone, SErr} state_e;
`else
    typedef enum logic [2:0] {SLen0, SLen1, SData, SDone, SErr} state_e;
`endif

    rx_state_e       rx_state_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q, frame_err_q;

    state_e          state_q;
    logic [15:0]     len_q;
    logic [15:0]     word_cnt_q;
    logic [1:0]      byte_idx_q;
    logic [31:0]     word_q;
    logic [7:0]      csum_q;
    logic            we_q, hold_q, done_q, err_q;
    logic [31:0]     addr_q, wdata_q;
    logic [15:0]     new_len;

    assign new_len = {shift_q, len_q[7:0]};

    // Receiver: rx_prev_q keeps the previous synchronized sample for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        cnt_q      <= '0;
                        rx_state_q <= RxStart;
                    end
                end
                RxStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxData: begin
                    if (cnt_q == CntFull) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxStop: begin
                    if (cnt_q == CntFull) begin
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= ~rx_sync_q;
                        rx_state_q   <= RxIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SLen0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            // Address/count advance the cycle after each strobe.
            if (we_q) begin
                addr_q     <= addr_q + 32'd4;
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (frame_err_q && state_q != SDone) begin
                state_q <= SErr;
                err_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    SLen0: begin
                        if (byte_valid_q) begin
                            len_q[7:0] <= shift_q;
                            state_q    <= SLen1;
                        end
                    end
                    SLen1: begin
                        if (byte_valid_q) begin
                            len_q[15:8] <= shift_q;
                            if (new_len == 16'd0) begin
                                state_q <= SDone;
                                done_q  <= 1'b1;
                                hold_q  <= 1'b0;
                            end else if (32'(new_len) > MAX_WORDS) begin
                                state_q <= SErr;
                                err_q   <= 1'b1;
                            end else begin
                                state_q    <= SData;
                                byte_idx_q <= '0;
                                word_cnt_q <= '0;
                            end
                        end
                    end
                    SData: begin
                        if (byte_valid_q) begin
                            word_q     <= {shift_q, word_q[31:8]};
                            byte_idx_q <= byte_idx_q + 2'd1;
                            csum_q     <= csum_q ^ shift_q;
                            if (byte_idx_q == 2'd3) begin
                                we_q    <= 1'b1;
                                wdata_q <= {shift_q, word_q[31:8]};
                            end
                        end
                        if (we_q && (word_cnt_q + 16'd1) == len_q) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                            state_q <= SCsum;
`else
                            state_q <= SDone;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
`endif
                        end
                    end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                    SCsum: begin
                        if (byte_valid_q) begin
                            if (shift_q == csum_q) begin
                                state_q <= SDone;
                                done_q  <= 1'b1;
                                hold_q  <= 1'b0;
                            end else begin
                                state_q <= SErr;
                                err_q   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: serial frames are driven bit by bit and write strobes are
// recorded on the falling clock edge for comparison against hand-computed words.
module tb_uart_imem_loader;

    localparam int unsigned Cpb = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        core_hold, load_done, load_error;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base = 0;
    logic [31:0] rec_addr [0:63];
    logic [31:0] rec_data [0:63];

    uart_imem_loader #(
        .CLKS_PER_BIT(Cpb),
        .BASE_ADDR   (32'h0000_0000),
        .MAX_WORDS   (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            rec_addr[pulses % 64] <= imem_addr;
            rec_data[pulses % 64] <= imem_wdata;
            pulses                <= pulses + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(Cpb);
        end
        uart_rx = stop;
        tick(Cpb);
        uart_rx = 1'b1;
        tick(Cpb);
    endtask

    initial begin
        tick(2);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Partial image, then reset in the middle of a byte.
        base = pulses;
        send(8'h02, 1'b1); send(8'h00, 1'b1);
        send(8'h13, 1'b1); send(8'h05, 1'b1); send(8'hA0, 1'b1); send(8'h00, 1'b1);
        tick(4);
        check("part_pulses", 32'(pulses - base), 32'd1);
        check("part_addr", imem_addr, 32'h4);
        uart_rx = 1'b0;
        tick(20);
        rst_n = 1'b0;
        tick(3);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_hold", 32'(core_hold), 32'd1);
        uart_rx = 1'b1;
        rst_n   = 1'b1;
        tick(2);
        check("postrst_we", 32'(imem_we), 32'd0);
        check("postrst_done", 32'(load_done), 32'd0);
        check("postrst_wdata", imem_wdata, 32'h0);

        // Two-word image.
        base = pulses;
        send(8'h02, 1'b1); send(8'h00, 1'b1);
        send(8'h13, 1'b1); send(8'h05, 1'b1); send(8'hA0, 1'b1); send(8'h00, 1'b1);
        send(8'h93, 1'b1); send(8'h05, 1'b1); send(8'h10, 1'b1); send(8'h00, 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send(8'h30, 1'b1);
`endif
        tick(4);
        check("img_pulses", 32'(pulses - base), 32'd2);
        check("img_addr0", rec_addr[base % 64], 32'h0);
        check("img_data0", rec_data[base % 64], 32'h00A00513);
        check("img_addr1", rec_addr[(base + 1) % 64], 32'h4);
        check("img_data1", rec_data[(base + 1) % 64], 32'h00100593);
        check("img_done", 32'(load_done), 32'd1);
        check("img_hold", 32'(core_hold), 32'd0);
        check("img_err", 32'(load_error), 32'd0);
        send(8'h55, 1'b1);
        tick(4);
        check("done_ignore", 32'(pulses - base), 32'd2);

        // Zero-length image.
        do_reset();
        base = pulses;
        send(8'h00, 1'b1); send(8'h00, 1'b1);
        tick(4);
        check("len0_pulses", 32'(pulses - base), 32'd0);
        check("len0_done", 32'(load_done), 32'd1);
        check("len0_hold", 32'(core_hold), 32'd0);

        // Framing error on the third byte.
        do_reset();
        base = pulses;
        send(8'h01, 1'b1); send(8'h00, 1'b1); send(8'h13, 1'b0);
        send(8'h05, 1'b1); send(8'hA0, 1'b1); send(8'h00, 1'b1); send(8'h11, 1'b1);
        tick(4);
        check("ferr_err", 32'(load_error), 32'd1);
        check("ferr_hold", 32'(core_hold), 32'd1);
        check("ferr_done", 32'(load_done), 32'd0);
        check("ferr_pulses", 32'(pulses - base), 32'd0);

        // Short low glitch must not produce a byte.
        do_reset();
        base = pulses;
        send(8'h01, 1'b1); send(8'h00, 1'b1);
        uart_rx = 1'b0;
        tick(Cpb / 4);
        uart_rx = 1'b1;
        tick(3 * Cpb);
        check("glitch_err", 32'(load_error), 32'd0);
        send(8'h5A, 1'b1); send(8'h12, 1'b1); send(8'h34, 1'b1); send(8'h56, 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send(8'h2A, 1'b1);
`endif
        tick(4);
        check("glitch_pulses", 32'(pulses - base), 32'd1);
        check("glitch_addr", rec_addr[base % 64], 32'h0);
        check("glitch_data", rec_data[base % 64], 32'h5634125A);
        check("glitch_done", 32'(load_done), 32'd1);

        // Length limits.
        do_reset();
        send(8'h01, 1'b1); send(8'h01, 1'b1);
        tick(4);
        check("len257_err", 32'(load_error), 32'd1);
        check("len257_hold", 32'(core_hold), 32'd1);
        do_reset();
        send(8'h00, 1'b1); send(8'h01, 1'b1);
        tick(4);
        check("len256_err", 32'(load_error), 32'd0);
        check("len256_done", 32'(load_done), 32'd0);

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        do_reset();
        send(8'h01, 1'b1); send(8'h00, 1'b1);
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
        tick(4);
        check("csum_wait_done", 32'(load_done), 32'd0);
        send(8'h44, 1'b1);
        tick(4);
        check("csum_ok_done", 32'(load_done), 32'd1);
        check("csum_ok_err", 32'(load_error), 32'd0);
        do_reset();
        send(8'h01, 1'b1); send(8'h00, 1'b1);
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
        send(8'h45, 1'b1);
        tick(4);
        check("csum_bad_err", 32'(load_error), 32'd1);
        check("csum_bad_done", 32'(load_done), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
